i2c_txn_sequencer: RTL and testbench

Transaction-level controller for the I2C master byte engine. Accepts single-byte register write and register read requests from up to `NREQ` requesters and arbitrates between them round-robin. Each granted request is expanded into the byte-engine command sequence (START, address, register, data or repeated-START/read, STOP). Returns read data and ACK/timeout status to the requester that issued it.

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/i2c_txn_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction sequencer: byte-engine opcodes,
// sequencer state encoding and the R/W bit appended to the slave address.
package i2c_pkg;

  typedef enum logic [2:0] {
    OP_START  = 3'd0,
    OP_RSTART = 3'd1,
    OP_WRITE  = 3'd2,
    OP_READ   = 3'd3,
    OP_STOP   = 3'd4
  } i2c_op_t;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t ST_IDLE   = 4'd0;
  localparam seq_state_t ST_START  = 4'd1;
  localparam seq_state_t ST_DEV_W  = 4'd2;
  localparam seq_state_t ST_REG    = 4'd3;
  localparam seq_state_t ST_WDATA  = 4'd4;
  localparam seq_state_t ST_RSTART = 4'd5;
  localparam seq_state_t ST_DEV_R  = 4'd6;
  localparam seq_state_t ST_READ   = 4'd7;
  localparam seq_state_t ST_STOP   = 4'd8;
  localparam seq_state_t ST_RESP   = 4'd9;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Only bytes the slave must acknowledge can abort the transaction.
  function automatic logic nack_aborts(input seq_state_t s);
    return (s == ST_DEV_W) || (s == ST_REG) || (s == ST_WDATA) || (s == ST_DEV_R);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 with wrap
// and returns a one-hot grant; the pointer register lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int LGW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LGW-1:0]  last_grant,
  input  logic            en,
  output logic [NREQ-1:0] grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// Expands arbitrated single-byte register read/write requests into I2C
// byte-engine command sequences and returns data plus ACK/timeout status.
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              scl_4x,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [7*NREQ-1:0] req_dev_addr,
  input  logic [8*NREQ-1:0] req_reg_addr,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_nack,
  output logic              rsp_timeout,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_op,
  output logic [7:0]        cmd_data,
  output logic              cmd_ack_out,
  input  logic              done_valid,
  input  logic [7:0]        done_data,
  input  logic              done_nack,
  output logic              busy,
  output seq_state_t        state_dbg
);

  localparam int LGW = (NREQ > 2) ? 2 : 1;

  // Handshakes: a request transfers on the cycle req_valid[i] & req_ready[i];
  // a command transfers on cmd_valid & cmd_ready, and cmd_op/cmd_data stay
  // stable while cmd_valid is high and cmd_ready is low.
  seq_state_t      state, next_on_done;
  logic            wait_ph;
  logic            lat_rw;
  logic [6:0]      lat_dev;
  logic [7:0]      lat_reg, lat_wdata, rdata;
  logic            nack_f, to_f;
  logic [LGW-1:0]  last_grant, grant_idx;
  logic [NREQ-1:0] grant;
  logic [12:0]     tcnt, tcnt_nxt;
  logic            xfer, cmd_state, timeout_hit, abort;
  logic            sel_rw;
  logic [6:0]      sel_dev;
  logic [7:0]      sel_reg, sel_wdata;

  rr_arbiter #(.NREQ(NREQ), .LGW(LGW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         ((state == ST_IDLE) && !rst),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign xfer      = |(req_valid & grant);

  always_comb begin
    grant_idx = '0;
    sel_rw    = 1'b0;
    sel_dev   = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_idx = LGW'(i);
        sel_rw    = req_rw[i];
        sel_dev   = req_dev_addr[7*i +: 7];
        sel_reg   = req_reg_addr[8*i +: 8];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  assign cmd_state   = (state != ST_IDLE) && (state != ST_RESP);
  assign tcnt_nxt    = tcnt + 13'd1;
  assign timeout_hit = (tcnt_nxt == 13'(TIMEOUT_CYC));
  assign abort       = nack_aborts(state) && done_nack;

  always_comb begin
    next_on_done = ST_IDLE;
    case (state)
      ST_START:  next_on_done = ST_DEV_W;
      ST_DEV_W:  next_on_done = ST_REG;
      ST_REG:    next_on_done = (lat_rw == RW_READ) ? ST_RSTART : ST_WDATA;
      ST_WDATA:  next_on_done = ST_STOP;
      ST_RSTART: next_on_done = ST_DEV_R;
      ST_DEV_R:  next_on_done = ST_READ;
      ST_READ:   next_on_done = ST_STOP;
      ST_STOP:   next_on_done = ST_RESP;
      default:   next_on_done = ST_IDLE;
    endcase
    if (abort) next_on_done = ST_STOP;
  end

  always_ff @(posedge scl_4x) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_ph    <= 1'b0;
      lat_rw     <= 1'b0;
      lat_dev    <= '0;
      lat_reg    <= '0;
      lat_wdata  <= '0;
      last_grant <= LGW'(NREQ - 1);
      rdata      <= '0;
      nack_f     <= 1'b0;
      to_f       <= 1'b0;
      tcnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            lat_rw     <= sel_rw;
            lat_dev    <= sel_dev;
            lat_reg    <= sel_reg;
            lat_wdata  <= sel_wdata;
            last_grant <= grant_idx;
            wait_ph    <= 1'b0;
            state      <= ST_START;
          end
        end
        ST_START, ST_DEV_W, ST_REG, ST_WDATA, ST_RSTART, ST_DEV_R, ST_READ, ST_STOP: begin
          if (!wait_ph) begin
            if (cmd_ready) begin
              wait_ph <= 1'b1;
              tcnt    <= '0;
            end
          end else if (done_valid) begin
            // done wins over a timeout landing on the same edge
            wait_ph <= 1'b0;
            if (state == ST_READ) rdata <= done_data;
            if (abort) nack_f <= 1'b1;
            state <= next_on_done;
          end else if (timeout_hit) begin
            wait_ph <= 1'b0;
            to_f    <= 1'b1;
            nack_f  <= 1'b1;
            state   <= (state == ST_STOP) ? ST_RESP : ST_STOP;
          end else begin
            tcnt <= tcnt_nxt;
          end
        end
        ST_RESP: begin
          rdata  <= '0;
          nack_f <= 1'b0;
          to_f   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid = cmd_state && !wait_ph;

  always_comb begin
    cmd_op      = OP_START;
    cmd_data    = '0;
    cmd_ack_out = 1'b0;
    if (cmd_valid) begin
      case (state)
        ST_START:  cmd_op = OP_START;
        ST_DEV_W:  begin cmd_op = OP_WRITE; cmd_data = {lat_dev, RW_WRITE}; end
        ST_REG:    begin cmd_op = OP_WRITE; cmd_data = lat_reg; end
        ST_WDATA:  begin cmd_op = OP_WRITE; cmd_data = lat_wdata; end
        ST_RSTART: cmd_op = OP_RSTART;
        ST_DEV_R:  begin cmd_op = OP_WRITE; cmd_data = {lat_dev, RW_READ}; end
        ST_READ:   begin cmd_op = OP_READ; cmd_ack_out = 1'b1; end
        ST_STOP:   cmd_op = OP_STOP;
        default:   cmd_op = OP_START;
      endcase
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESP) rsp_valid[last_grant] = 1'b1;
  end

  assign rsp_rdata   = (state == ST_RESP) ? rdata : 8'h00;
  assign rsp_nack    = (state == ST_RESP) && nack_f;
  assign rsp_timeout = (state == ST_RESP) && to_f;
  assign busy        = (state != ST_IDLE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: scripted byte-engine model, expected
// queues for commands, responses and grants, and monitors that pop and compare.
module tb_i2c_txn_sequencer;
  import i2c_pkg::*;

  localparam int NREQ = 2;
  localparam int TO   = 16;

  typedef struct packed {
    logic       withhold;
    logic [4:0] lat;
    logic       nack;
    logic [7:0] data;
  } react_t;

  logic              scl_4x = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_rw = '0;
  logic [7*NREQ-1:0] req_dev_addr = '0;
  logic [8*NREQ-1:0] req_reg_addr = '0;
  logic [8*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_nack, rsp_timeout;
  logic              cmd_valid;
  logic              cmd_ready = 1'b1;
  logic [2:0]        cmd_op;
  logic [7:0]        cmd_data;
  logic              cmd_ack_out;
  logic              done_valid = 1'b0;
  logic [7:0]        done_data = '0;
  logic              done_nack = 1'b0;
  logic              busy;
  seq_state_t        state_dbg;

  i2c_txn_sequencer #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .scl_4x(scl_4x), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ack_out(cmd_ack_out), .done_valid(done_valid), .done_data(done_data),
    .done_nack(done_nack), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 scl_4x = ~scl_4x;

  int cyc = 0;
  always @(posedge scl_4x) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int rsp_count = 0;
  int acc_count = 0;

  logic [11:0]     exp_cmd_q[$];
  logic [NREQ+9:0] exp_rsp_q[$];
  logic [1:0]      exp_gnt_q[$];
  react_t          react_q[$];

  logic [11:0]     cmd_e;
  logic [NREQ+9:0] rsp_e;
  logic [1:0]      gnt_e, gnt_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_cmd(input logic [2:0] op, input logic [7:0] data, input logic ack);
    exp_cmd_q.push_back({op, data, ack});
  endtask

  task automatic push_rsp(input logic [NREQ-1:0] v, input logic [7:0] rd, input logic nk, input logic to);
    exp_rsp_q.push_back({v, rd, nk, to});
  endtask

  task automatic push_react(input logic wh, input logic [4:0] lat, input logic nk, input logic [7:0] d);
    react_t r;
    r.withhold = wh; r.lat = lat; r.nack = nk; r.data = d;
    react_q.push_back(r);
  endtask

  task automatic push_write_seq(input logic [7:0] addr_w, input logic [7:0] rg, input logic [7:0] wd);
    push_cmd(OP_START, 8'h00, 1'b0);
    push_cmd(OP_WRITE, addr_w, 1'b0);
    push_cmd(OP_WRITE, rg, 1'b0);
    push_cmd(OP_WRITE, wd, 1'b0);
    push_cmd(OP_STOP, 8'h00, 1'b0);
  endtask

  // ---------------- byte-engine model ----------------
  logic   stall_en = 1'b0;
  logic   eng_busy = 1'b0;
  logic   wh_seen = 1'b0;
  int     eng_cnt = 0;
  int     wh_cyc = 0;
  int     post_wh_cyc = 0;
  react_t eng_cur;

  always @(posedge scl_4x) begin
    #2;
    cmd_ready = stall_en ? ((cyc % 3) != 0) : 1'b1;
  end

  always @(negedge scl_4x) begin
    done_valid = 1'b0;
    done_nack  = 1'b0;
    done_data  = 8'h00;
    if (rst) begin
      eng_busy = 1'b0;
      wh_seen  = 1'b0;
    end else begin
      if (eng_busy && !eng_cur.withhold) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          done_valid = 1'b1;
          done_nack  = eng_cur.nack;
          done_data  = eng_cur.data;
          eng_busy   = 1'b0;
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (react_q.size() > 0) eng_cur = react_q.pop_front();
        else begin
          eng_cur.withhold = 1'b0; eng_cur.lat = 5'd2; eng_cur.nack = 1'b0; eng_cur.data = 8'h00;
        end
        eng_busy = 1'b1;
        eng_cnt  = int'(eng_cur.lat);
        if (wh_seen) begin post_wh_cyc = cyc; wh_seen = 1'b0; end
        if (eng_cur.withhold) begin wh_cyc = cyc; wh_seen = 1'b1; end
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge scl_4x) begin
    if (!rst && cmd_valid && cmd_ready) begin
      if (exp_cmd_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL cmd_unexpected: got op %0d data 0x%0h, expected no command (cycle %0d)", cmd_op, cmd_data, cyc);
      end else begin
        cmd_e = exp_cmd_q.pop_front();
        check("cmd_op_data_ack", {20'h0, cmd_op, cmd_data, cmd_ack_out}, {20'h0, cmd_e});
      end
    end
  end

  always @(negedge scl_4x) begin
    if (rsp_valid !== '0) begin
      rsp_count++;
      if (exp_rsp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL rsp_unexpected: got rsp_valid %b, expected none (cycle %0d)", rsp_valid, cyc);
      end else begin
        rsp_e = exp_rsp_q.pop_front();
        check("rsp_valid_rdata_nack_to", {rsp_valid, rsp_rdata, rsp_nack, rsp_timeout}, rsp_e);
      end
    end
  end

  always @(negedge scl_4x) begin
    if (!rst && ((req_valid & req_ready) != '0)) begin
      acc_count++;
      gnt_a = 2'd0;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gnt_a = 2'(i);
      check("req_ready_onehot", {31'h0, $onehot(req_ready)}, 32'h1);
      if (exp_gnt_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL grant_unexpected: got grant %0d, expected none (cycle %0d)", gnt_a, cyc);
      end else begin
        gnt_e = exp_gnt_q.pop_front();
        check("grant_index", {30'h0, gnt_a}, {30'h0, gnt_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue_req(input int i, input logic rw, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd);
    int k;
    @(posedge scl_4x); #2;
    req_rw[i] = rw;
    req_dev_addr[7*i +: 7] = dev;
    req_reg_addr[8*i +: 8] = rg;
    req_wdata[8*i +: 8] = wd;
    req_valid[i] = 1'b1;
    for (k = 0; k < 500; k++) begin
      @(negedge scl_4x);
      if (req_ready[i]) break;
    end
    check("req_accept", {31'h0, req_ready[i]}, 32'h1);
    check("idle_not_busy", {31'h0, busy}, 32'h0);
    @(posedge scl_4x); #2;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input string name);
    for (int k = 0; k < 2000 && rsp_count < target; k++) @(negedge scl_4x);
    repeat (2) @(negedge scl_4x);
    check(name, rsp_count, target);
  endtask

  task automatic end_checks(input string name);
    check({name, "_cmd_q_empty"}, exp_cmd_q.size(), 0);
    check({name, "_rsp_q_empty"}, exp_rsp_q.size(), 0);
    check({name, "_gnt_q_empty"}, exp_gnt_q.size(), 0);
    check({name, "_react_q_empty"}, react_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rsp_before;
    // Both requesters present from reset for the contention case.
    req_valid    = 2'b11;
    req_rw       = 2'b00;
    req_dev_addr = {7'h21, 7'h10};
    req_reg_addr = {8'h02, 8'h01};
    req_wdata    = {8'h22, 8'h11};
    repeat (3) @(negedge scl_4x);
    check("rst_req_ready", {30'h0, req_ready}, 32'h0);
    check("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_state", {28'h0, state_dbg}, {28'h0, ST_IDLE});
    check("rst_cmd_op_data", {21'h0, cmd_op, cmd_data}, 32'h0);

    // Contention: grants 0,1,0,1 with command backpressure.
    stall_en = 1'b1;
    exp_gnt_q.push_back(2'd0); exp_gnt_q.push_back(2'd1);
    exp_gnt_q.push_back(2'd0); exp_gnt_q.push_back(2'd1);
    push_write_seq(8'h20, 8'h01, 8'h11); push_rsp(2'b01, 8'h00, 1'b0, 1'b0);
    push_write_seq(8'h42, 8'h02, 8'h22); push_rsp(2'b10, 8'h00, 1'b0, 1'b0);
    push_write_seq(8'h20, 8'h01, 8'h11); push_rsp(2'b01, 8'h00, 1'b0, 1'b0);
    push_write_seq(8'h42, 8'h02, 8'h22); push_rsp(2'b10, 8'h00, 1'b0, 1'b0);
    @(posedge scl_4x); #2; rst = 1'b0;
    for (int k = 0; k < 2000 && acc_count < 4; k++) @(negedge scl_4x);
    @(posedge scl_4x); #2; req_valid = 2'b00;
    check("contention_accepts", acc_count, 4);
    wait_rsp(4, "contention_rsp_count");
    end_checks("contention");

    // Write, all ACK; START must appear the cycle after the accept.
    exp_gnt_q.push_back(2'd0);
    push_write_seq(8'hA0, 8'h92, 8'hAC);
    push_rsp(2'b01, 8'h00, 1'b0, 1'b0);
    issue_req(0, 1'b0, 7'h50, 8'h92, 8'hAC);
    check("start_cmd_valid", {31'h0, cmd_valid}, 32'h1);
    check("start_busy", {31'h0, busy}, 32'h1);
    check("start_op", {29'h0, cmd_op}, 32'h0);
    wait_rsp(5, "write_rsp_count");
    end_checks("write");
    stall_en = 1'b0;

    // Read; NACK on RSTART and READ must be ignored.
    exp_gnt_q.push_back(2'd1);
    push_cmd(OP_START, 8'h00, 1'b0);
    push_cmd(OP_WRITE, 8'hA0, 1'b0);
    push_cmd(OP_WRITE, 8'h92, 1'b0);
    push_cmd(OP_RSTART, 8'h00, 1'b0);
    push_cmd(OP_WRITE, 8'hA1, 1'b0);
    push_cmd(OP_READ, 8'h00, 1'b1);
    push_cmd(OP_STOP, 8'h00, 1'b0);
    push_rsp(2'b10, 8'h5A, 1'b0, 1'b0);
    push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b0, 5'd2, 1'b1, 8'h00);
    push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b0, 5'd3, 1'b1, 8'h5A);
    issue_req(1, 1'b1, 7'h50, 8'h92, 8'h00);
    wait_rsp(6, "read_rsp_count");
    end_checks("read");

    // Address NACK: REG is never issued.
    exp_gnt_q.push_back(2'd0);
    push_cmd(OP_START, 8'h00, 1'b0);
    push_cmd(OP_WRITE, 8'hA0, 1'b0);
    push_cmd(OP_STOP, 8'h00, 1'b0);
    push_rsp(2'b01, 8'h00, 1'b1, 1'b0);
    push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b0, 5'd2, 1'b1, 8'h00);
    issue_req(0, 1'b0, 7'h50, 8'h92, 8'hAC);
    wait_rsp(7, "nack_rsp_count");
    end_checks("nack");

    // Timeout after the REG write: STOP 17 cycles after REG accept.
    exp_gnt_q.push_back(2'd0);
    push_cmd(OP_START, 8'h00, 1'b0);
    push_cmd(OP_WRITE, 8'h66, 1'b0);
    push_cmd(OP_WRITE, 8'h44, 1'b0);
    push_cmd(OP_STOP, 8'h00, 1'b0);
    push_rsp(2'b01, 8'h00, 1'b1, 1'b1);
    push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b1, 5'd2, 1'b0, 8'h00);
    issue_req(0, 1'b0, 7'h33, 8'h44, 8'h55);
    wait_rsp(8, "timeout_rsp_count");
    check("timeout_stop_gap", post_wh_cyc - wh_cyc, 17);
    end_checks("timeout");

    // STOP that times out goes straight to the response.
    exp_gnt_q.push_back(2'd1);
    push_write_seq(8'h24, 8'h34, 8'h56);
    push_rsp(2'b10, 8'h00, 1'b1, 1'b1);
    repeat (4) push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b1, 5'd2, 1'b0, 8'h00);
    issue_req(1, 1'b0, 7'h12, 8'h34, 8'h56);
    wait_rsp(9, "stop_to_rsp_count");
    end_checks("stop_to");

    // done_valid on the same edge as the timeout wins.
    exp_gnt_q.push_back(2'd0);
    push_write_seq(8'h14, 8'h0B, 8'h0C);
    push_rsp(2'b01, 8'h00, 1'b0, 1'b0);
    push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b0, 5'd16, 1'b0, 8'h00);
    issue_req(0, 1'b0, 7'h0A, 8'h0B, 8'h0C);
    wait_rsp(10, "coincide_rsp_count");
    end_checks("coincide");

    // Reset pulsed while the READ is outstanding.
    exp_gnt_q.push_back(2'd0);
    push_cmd(OP_START, 8'h00, 1'b0);
    push_cmd(OP_WRITE, 8'hA0, 1'b0);
    push_cmd(OP_WRITE, 8'h92, 1'b0);
    push_cmd(OP_RSTART, 8'h00, 1'b0);
    push_cmd(OP_WRITE, 8'hA1, 1'b0);
    push_cmd(OP_READ, 8'h00, 1'b1);
    repeat (5) push_react(1'b0, 5'd2, 1'b0, 8'h00);
    push_react(1'b1, 5'd2, 1'b0, 8'h00);
    issue_req(0, 1'b1, 7'h50, 8'h92, 8'h00);
    for (int k = 0; k < 500 && exp_cmd_q.size() != 0; k++) @(negedge scl_4x);
    repeat (3) @(negedge scl_4x);
    rsp_before = rsp_count;
    @(posedge scl_4x); #2; rst = 1'b1;
    @(posedge scl_4x); #2; rst = 1'b0;
    @(negedge scl_4x);
    check("midrst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    check("midrst_state", {28'h0, state_dbg}, {28'h0, ST_IDLE});
    repeat (5) @(negedge scl_4x);
    check("midrst_no_rsp", rsp_count, rsp_before);
    end_checks("midrst");

    // Normal write after the reset.
    exp_gnt_q.push_back(2'd0);
    push_write_seq(8'h78, 8'h0F, 8'hF0);
    push_rsp(2'b01, 8'h00, 1'b0, 1'b0);
    issue_req(0, 1'b0, 7'h3C, 8'h0F, 8'hF0);
    wait_rsp(rsp_before + 1, "post_rst_rsp_count");
    end_checks("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
